// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause plus 64-bit mcycle/minstret
// with user-level read-only counter aliases. Reads are combinational; writes and counts on clk.
`timescale 1ns/1ps
module csr_file #(
  parameter logic [31:0] MTVEC_RST     = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_WMASK = 32'h0000_1888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] CsrRdAddr,
  output logic [31:0] CsrRdData,
  output logic        CsrIllegal,
  input  logic        CsrWe,
  input  logic [11:0] CsrWrAddr,
  input  logic [1:0]  CsrWrOp,
  input  logic [31:0] CsrWrSrc,
  input  logic        RetireValid
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned CW   = 64;

  localparam logic [AW-1:0] A_MSTATUS   = 12'h300;
  localparam logic [AW-1:0] A_MTVEC     = 12'h305;
  localparam logic [AW-1:0] A_MSCRATCH  = 12'h340;
  localparam logic [AW-1:0] A_MEPC      = 12'h341;
  localparam logic [AW-1:0] A_MCAUSE    = 12'h342;
  localparam logic [AW-1:0] A_MCYCLE    = 12'hB00;
  localparam logic [AW-1:0] A_MINSTRET  = 12'hB02;
  localparam logic [AW-1:0] A_MCYCLEH   = 12'hB80;
  localparam logic [AW-1:0] A_MINSTRETH = 12'hB82;
  localparam logic [AW-1:0] A_CYCLE     = 12'hC00;
  localparam logic [AW-1:0] A_INSTRET   = 12'hC02;
  localparam logic [AW-1:0] A_CYCLEH    = 12'hC80;
  localparam logic [AW-1:0] A_INSTRETH  = 12'hC82;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [CW-1:0]   mcycle;
  logic [CW-1:0]   minstret;

  logic [CW-1:0]   mcycle_nxt;
  logic [CW-1:0]   minstret_nxt;
  logic [CW-1:0]   mcycle_inc;
  logic [CW-1:0]   minstret_inc;

  logic            wr_act;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_val;
  logic            wr_old_ill;
  logic            sel_mstatus;
  logic            sel_mtvec;
  logic            sel_mscratch;
  logic            sel_mepc;
  logic            sel_mcause;
  logic            sel_mcycle;
  logic            sel_mcycleh;
  logic            sel_minstret;
  logic            sel_minstreth;

  // Shared address decode for the read port and the write read-modify-write path.
  function automatic logic [XLEN:0] csr_lookup(input logic [AW-1:0] addr);
    logic [XLEN:0] r;
    r = {1'b0, {XLEN{1'b0}}};
    unique case (addr)
      A_MSTATUS:                r[XLEN-1:0] = mstatus;
      A_MTVEC:                  r[XLEN-1:0] = mtvec;
      A_MSCRATCH:               r[XLEN-1:0] = mscratch;
      A_MEPC:                   r[XLEN-1:0] = mepc;
      A_MCAUSE:                 r[XLEN-1:0] = mcause;
      A_MCYCLE,   A_CYCLE:      r[XLEN-1:0] = mcycle[XLEN-1:0];
      A_MCYCLEH,  A_CYCLEH:     r[XLEN-1:0] = mcycle[CW-1:XLEN];
      A_MINSTRET, A_INSTRET:    r[XLEN-1:0] = minstret[XLEN-1:0];
      A_MINSTRETH, A_INSTRETH:  r[XLEN-1:0] = minstret[CW-1:XLEN];
      default:                  r[XLEN]     = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] apply_op(input logic [1:0] op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] src);
    logic [XLEN-1:0] r;
    r = old;
    unique case (op)
      OP_RW:   r = src;
      OP_RS:   r = old | src;
      OP_RC:   r = old & ~src;
      default: r = old;
    endcase
    return r;
  endfunction

  // Read port: always the registered (pre-edge) value, never the pending write.
  always_comb begin
    {CsrIllegal, CsrRdData} = csr_lookup(CsrRdAddr);
  end

  // Set/clear with a zero source is not a write, so counters keep incrementing.
  always_comb begin
    wr_act = CsrWe && (CsrWrOp != OP_NONE) &&
             !((CsrWrOp != OP_RW) && (CsrWrSrc == {XLEN{1'b0}}));
    {wr_old_ill, wr_old} = csr_lookup(CsrWrAddr);
    wr_val = apply_op(CsrWrOp, wr_old, CsrWrSrc);
  end

  // Only the machine-writable addresses decode; read-only aliases and holes drop the write.
  always_comb begin
    sel_mstatus   = 1'b0;
    sel_mtvec     = 1'b0;
    sel_mscratch  = 1'b0;
    sel_mepc      = 1'b0;
    sel_mcause    = 1'b0;
    sel_mcycle    = 1'b0;
    sel_mcycleh   = 1'b0;
    sel_minstret  = 1'b0;
    sel_minstreth = 1'b0;
    if (wr_act && !wr_old_ill) begin
      unique case (CsrWrAddr)
        A_MSTATUS:   sel_mstatus   = 1'b1;
        A_MTVEC:     sel_mtvec     = 1'b1;
        A_MSCRATCH:  sel_mscratch  = 1'b1;
        A_MEPC:      sel_mepc      = 1'b1;
        A_MCAUSE:    sel_mcause    = 1'b1;
        A_MCYCLE:    sel_mcycle    = 1'b1;
        A_MCYCLEH:   sel_mcycleh   = 1'b1;
        A_MINSTRET:  sel_minstret  = 1'b1;
        A_MINSTRETH: sel_minstreth = 1'b1;
        default:     ;
      endcase
    end
  end

  // A written half takes the value exactly; writing the low half also suppresses the carry.
  always_comb begin
    mcycle_inc   = mcycle + CW'(1);
    minstret_inc = minstret + CW'(RetireValid);
    mcycle_nxt   = mcycle_inc;
    minstret_nxt = minstret_inc;
    if (sel_mcycle)    mcycle_nxt   = {mcycle[CW-1:XLEN], wr_val};
    if (sel_mcycleh)   mcycle_nxt   = {wr_val, mcycle_inc[XLEN-1:0]};
    if (sel_minstret)  minstret_nxt = {minstret[CW-1:XLEN], wr_val};
    if (sel_minstreth) minstret_nxt = {wr_val, minstret_inc[XLEN-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= '0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (sel_mstatus)  mstatus  <= wr_val & MSTATUS_WMASK;
      if (sel_mtvec)    mtvec    <= wr_val & ALIGN_MASK;
      if (sel_mscratch) mscratch <= wr_val;
      if (sel_mepc)     mepc     <= wr_val & ALIGN_MASK;
      if (sel_mcause)   mcause   <= wr_val;
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
    end
  end

endmodule
